// File: rtl/potential_arbiter_if.sv
// Lane/memory-side bundle for the potential memory arbiter.
// The master side is the set of lanes plus the memory wrapper; the slave side is the arbiter.
interface potential_arbiter_if #(
  parameter int NUM_ARB = 6,
  parameter int DEPTH   = 16,
  parameter int WIDTH   = 32
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [NUM_ARB-1:0]       rd_req;
  logic [NUM_ARB*AW-1:0]    rd_addr;
  logic [NUM_ARB-1:0]       wr_req;
  logic [NUM_ARB*AW-1:0]    wr_addr;
  logic [NUM_ARB*WIDTH-1:0] wr_data;
  logic [NUM_ARB-1:0]       read_grant;
  logic [NUM_ARB-1:0]       write_grant;
  logic [NUM_ARB-1:0]       rd_ack;
  logic [NUM_ARB-1:0]       wr_ack;
  logic [WIDTH-1:0]         mem_read_data;
  logic                     mem_flag;
  logic [NUM_ARB-1:0]       rsp_valid;
  logic [WIDTH-1:0]         rsp_data;
  logic                     rsp_flag;

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data, mem_read_data, mem_flag,
    input  read_grant, write_grant, rd_ack, wr_ack, rsp_valid, rsp_data, rsp_flag
  );

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data, mem_read_data, mem_flag,
    output read_grant, write_grant, rd_ack, wr_ack, rsp_valid, rsp_data, rsp_flag
  );
endinterface

// File: rtl/potential_arbiter.sv
// Round-robin arbiter sharing one read and one write port of the potential memory
// between NUM_ARB lanes. Reads that hit the address being written this cycle are
// masked; a saturating starvation counter eventually holds the write channel off.
module potential_arbiter #(
  parameter int NUM_ARB    = 6,
  parameter int DEPTH      = 16,
  parameter int WIDTH      = 32,
  parameter int STARVE_MAX = 4
) (
  input logic            clk,
  input logic            rst,
  potential_arbiter_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = (NUM_ARB > 1) ? $clog2(NUM_ARB) : 1;
  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  typedef logic [PW-1:0] ptr_t;

  typedef struct packed {
    logic found;
    ptr_t idx;
  } pick_t;

  // First requesting lane at ptr, ptr+1, ... (mod NUM_ARB). Scanning from the far end
  // down lets the closest lane overwrite earlier hits, so no early exit is needed.
  function automatic pick_t rr_pick(input logic [NUM_ARB-1:0] req, input ptr_t ptr);
    pick_t p;
    int    lane;
    ptr_t  li;
    p = '0;
    for (int off = NUM_ARB - 1; off >= 0; off--) begin
      lane = int'(ptr) + off;
      if (lane >= NUM_ARB) lane -= NUM_ARB;
      li = ptr_t'(lane);
      if (req[li]) begin
        p.found = 1'b1;
        p.idx   = li;
      end
    end
    return p;
  endfunction

  function automatic ptr_t next_ptr(input ptr_t k);
    return (int'(k) == NUM_ARB - 1) ? '0 : ptr_t'(k + 1'b1);
  endfunction

  ptr_t               rd_ptr;
  ptr_t               wr_ptr;
  logic [2:0]         starve_cnt;
  logic [NUM_ARB-1:0] rsp_lane;
  logic               flag_q;

  logic               hold_wr;
  logic [NUM_ARB-1:0] rd_req_v;
  logic [NUM_ARB-1:0] wr_req_v;
  logic [NUM_ARB-1:0] rd_elig;
  logic [NUM_ARB-1:0] rd_masked;
  logic [NUM_ARB-1:0] rd_grant;
  logic [NUM_ARB-1:0] wr_grant;
  logic [AW-1:0]      sel_wr_addr;
  pick_t              rd_pick;
  pick_t              wr_pick;

  logic [AW-1:0] rd_addr_lane [NUM_ARB];
  logic [AW-1:0] wr_addr_lane [NUM_ARB];

  // Write data travels to the wrapper directly; arbitration never looks at it.
  logic unused_wr_data;
  assign unused_wr_data = ^bus.wr_data;

  // Requests are ignored while reset is high so no grant can leak out.
  assign rd_req_v = bus.rd_req & {NUM_ARB{~rst}};
  assign wr_req_v = bus.wr_req & {NUM_ARB{~rst}} & {NUM_ARB{~hold_wr}};
  assign hold_wr  = (starve_cnt == STARVE_LIM);

  // Per-lane address unpacking and collision masking against the granted write.
  for (genvar g = 0; g < NUM_ARB; g++) begin : g_lane
    logic collide;
    assign rd_addr_lane[g] = bus.rd_addr[g*AW +: AW];
    assign wr_addr_lane[g] = bus.wr_addr[g*AW +: AW];
    assign collide         = wr_pick.found && (rd_addr_lane[g] == sel_wr_addr);
    assign rd_elig[g]      = rd_req_v[g] & ~collide;
    assign rd_masked[g]    = rd_req_v[g] & collide;
  end

  // Write channel arbitrates first; its winning address then filters the read channel.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, otherwise a
    // path that skips an assignment infers a latch.
    wr_grant    = '0;
    rd_grant    = '0;
    wr_pick     = rr_pick(wr_req_v, wr_ptr);
    sel_wr_addr = wr_addr_lane[wr_pick.idx];
    rd_pick     = rr_pick(rd_elig, rd_ptr);
    if (wr_pick.found) wr_grant[wr_pick.idx] = 1'b1;
    if (rd_pick.found) rd_grant[rd_pick.idx] = 1'b1;
  end

  assign bus.read_grant  = rd_grant;
  assign bus.write_grant = wr_grant;
  assign bus.rd_ack      = rd_grant;
  assign bus.wr_ack      = wr_grant;

  // Round-robin pointers advance past the lane just granted and hold otherwise.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (rd_pick.found) rd_ptr <= next_ptr(rd_pick.idx);
      if (wr_pick.found) wr_ptr <= next_ptr(wr_pick.idx);
    end
  end

  // Starvation counter: counts cycles where a read is masked and nothing is read.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (rd_pick.found) begin
      starve_cnt <= '0;
    end else if ((|rd_masked) && (starve_cnt != STARVE_LIM)) begin
      starve_cnt <= starve_cnt + 3'd1;
    end
  end

  // Response path: remember which lane read and the freshness flag seen at grant time.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_lane <= '0;
      flag_q   <= 1'b0;
    end else begin
      rsp_lane <= rd_grant;
      if (rd_pick.found) flag_q <= bus.mem_flag;
    end
  end

  // A response in flight when reset rises is dropped immediately, not one cycle later.
  assign bus.rsp_valid = rsp_lane & {NUM_ARB{~rst}};
  assign bus.rsp_data  = bus.mem_read_data;
  assign bus.rsp_flag  = flag_q;
endmodule
